note_sequencer: RTL
===================

# note_sequencer

Plays back one chart produced by the song selector. It latches the 100-slot red/blue/yellow note vectors and the note total on a start pulse, then steps one slot per beat at a fixed rate. It judges the player's per-lane hit pulses against each slot and keeps hit, miss and remaining-note counts. It also drives a look-ahead window of upcoming notes to the display stage.

## Interface
Parameters:
- SLOTS, 100: chart length in slots; equals the note-vector width.
- BEAT_CYCLES, 12500000: clock cycles per slot (4 slots/s at 50 MHz); must be ≥ 2.
- WINDOW, 8: number of upcoming slots exposed per lane; 1 ≤ WINDOW ≤ SLOTS.

Ports:
- clk  in  1  system clock; one clock domain.
- reset  in  1  synchronous, active-high reset.
- start  in  1  single-cycle pulse; loads the chart and begins play.
- red_in, blue_in, yellow_in  in  SLOTS each  note vectors; bit SLOTS-1 is slot 0, the first slot played.
- total_notes_in  in  8  note count of the chart.
- hit_red, hit_blue, hit_yellow  in  1 each  single-cycle key-press pulses, already edge-detected upstream.
- lane_red, lane_blue, lane_yellow  out  WINDOW each  look-ahead window; bit WINDOW-1 is the current slot.
- hits, misses  out  8 each  saturating judgement counters.
- notes_left  out  8  notes not yet judged.
- beat  out  1  one-cycle pulse after each slot is judged.
- playing, done  out  1 each  state flags.

## Operation
- FSM states IDLE, PLAY, DONE; reset enters IDLE.
- IDLE or DONE with start = 1:
  - Load the three shift registers from the *_in vectors and notes_left from total_notes_in.
  - Clear hits, misses, slot index, beat counter and hit flags.
  - Go to PLAY.
- In PLAY, start is ignored; *_in changes after the load have no effect.
- Beat counter: counts 0 to BEAT_CYCLES-1, then wraps. The judge edge is the edge at which the count equals BEAT_CYCLES-1.
- Hit flags: one sticky flag per lane, set by that lane's hit pulse during PLAY and cleared on every judge edge.
  - Effective hit for a lane = flag OR pulse in the judge-edge cycle, so a coincident pulse counts toward the slot being judged.
  - Multiple pulses in one slot count once.
- Judge edge, per lane, using the current slot (register MSB):
  - Note present and effective hit: hit.
  - Note present and no hit: miss.
  - No note: the press is ignored, with no penalty.
- Counter updates on the judge edge:
  - hits += number of lane hits (0..3), saturating at 255.
  - misses += number of lane misses (0..3), saturating at 255.
  - notes_left -= number of notes in the slot (0..3), saturating at 0.
- Same edge: shift all three registers left by one with zero fill and increment the 7-bit slot index.
- The judge edge for slot SLOTS-1 moves the FSM to DONE.
- DONE holds all counters and outputs until start or reset. Hit pulses are ignored in IDLE and DONE.
- lane_x = shift register bits [SLOTS-1 : SLOTS-WINDOW].

## Timing
- Reset values: lane_* = 0, hits = 0, misses = 0, notes_left = 0, beat = 0, playing = 0, done = 0, FSM = IDLE.
- Reset is honoured in any state, including mid-PLAY; it wins over a simultaneous start.
- All outputs are registered.
- Start sampled at edge S:
  - Cycle after S: playing = 1, done = 0, windows show slots 0..WINDOW-1, counters cleared.
  - The first judge edge is the BEAT_CYCLES-th edge after S.
- Judge edge J:
  - Cycle after J: updated counters and shifted windows are visible, and beat = 1 for exactly that cycle.
  - After the final judge edge: playing = 0 and done = 1 in that same cycle.
- Total play duration: SLOTS × BEAT_CYCLES cycles from S to the final judge edge.
- start coincident with a judge edge in PLAY is ignored.
- A start in the same cycle as the final judge edge is also ignored, because the FSM is still in PLAY.

## Test plan
Bench settings: BEAT_CYCLES = 4, SLOTS = 100, WINDOW = 8.

1. red_in = bit 99 only, total = 1, start, one hit_red pulse 2 cycles later.
   - After first beat: hits = 1, misses = 0, notes_left = 0.
   - done = 1 on the cycle after the final (400th-cycle) judge edge.
2. All lanes' bit 99 set, total = 3, no presses.
   - First beat: misses = 3, hits = 0, notes_left = 0.
   - lane_red bit 7 = 0 after the shift.
3. blue slot 0 set, total = 1, hit_blue pulse exactly on the judge-edge cycle, plus hit_red pulses on an empty lane.
   - Result: hits = 1, misses = 0; the red presses are ignored.
   - Three hit_blue pulses in one slot still give hits = 1.
4. All three vectors all-ones, total = 90, no presses.
   - misses saturates at 255 at slot 85, and notes_left saturates at 0.
   - done = 1 after slot 99; counters hold.
5. start pulsed mid-PLAY: ignored, play continues.
   - start in DONE restarts with counters cleared and playing = 1 the next cycle.
6. reset asserted at slot 40: all outputs equal their reset values on the next cycle, FSM = IDLE.
   - reset and start asserted together: stays in IDLE.

Source files
------------

// File: rtl/note_sequencer.sv
// Chart playback sequencer.
// Latches a red/blue/yellow note chart on a start pulse, steps one slot every
// BEAT_CYCLES clocks, judges per-lane hit pulses against the current slot and
// keeps saturating hit/miss counters plus a remaining-note count.
// Ports:
//   clk, reset                      clock, synchronous active-high reset
//   start                           load chart and begin play (IDLE/DONE only)
//   red_in/blue_in/yellow_in        note vectors, MSB is slot 0
//   total_notes_in                  note count of the chart
//   hit_red/hit_blue/hit_yellow     single-cycle key-press pulses
//   lane_red/lane_blue/lane_yellow  look-ahead windows, MSB is current slot
//   hits, misses, notes_left        judgement counters
//   beat                            one-cycle pulse after each slot is judged
//   playing, done                   state flags
module note_sequencer #(
  parameter int unsigned SLOTS       = 100,
  parameter int unsigned BEAT_CYCLES = 12500000,
  parameter int unsigned WINDOW      = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [SLOTS-1:0]  red_in,
  input  logic [SLOTS-1:0]  blue_in,
  input  logic [SLOTS-1:0]  yellow_in,
  input  logic [7:0]        total_notes_in,
  input  logic              hit_red,
  input  logic              hit_blue,
  input  logic              hit_yellow,
  output logic [WINDOW-1:0] lane_red,
  output logic [WINDOW-1:0] lane_blue,
  output logic [WINDOW-1:0] lane_yellow,
  output logic [7:0]        hits,
  output logic [7:0]        misses,
  output logic [7:0]        notes_left,
  output logic              beat,
  output logic              playing,
  output logic              done
);

  localparam int unsigned CNT_W = (BEAT_CYCLES > 1) ? $clog2(BEAT_CYCLES) : 1;
  localparam int unsigned IDX_W = 7;
  localparam logic [CNT_W-1:0] BEAT_LAST = CNT_W'(BEAT_CYCLES - 1);
  localparam logic [IDX_W-1:0] SLOT_LAST = IDX_W'(SLOTS - 1);

  typedef enum logic [1:0] {IDLE, PLAY, DONE} state_t;

  state_t           state, state_nxt;
  logic             playing_nxt, done_nxt;

  logic [SLOTS-1:0] red_sr, blue_sr, yellow_sr;
  logic [CNT_W-1:0] beat_cnt;
  logic [IDX_W-1:0] slot_idx;
  logic [2:0]       hit_flag;  // {red, blue, yellow}

  logic             judge_c, load_c;
  logic [2:0]       note_c, pulse_c, eff_c;
  logic [1:0]       n_hit_c, n_miss_c, n_note_c;
  logic [8:0]       hits_sum_c, misses_sum_c;
  logic [7:0]       hits_upd_c, misses_upd_c, left_upd_c;

  function automatic logic [1:0] count3(input logic [2:0] v);
    return 2'({1'b0, v[0]} + {1'b0, v[1]} + {1'b0, v[2]});
  endfunction

  // Judge decode for the slot at the register MSBs
  always_comb begin
    judge_c      = (state == PLAY) && (beat_cnt == BEAT_LAST);
    load_c       = (state != PLAY) && start;
    note_c       = {red_sr[SLOTS-1], blue_sr[SLOTS-1], yellow_sr[SLOTS-1]};
    pulse_c      = {hit_red, hit_blue, hit_yellow};
    // a pulse in the judge cycle still counts toward the slot being judged
    eff_c        = hit_flag | pulse_c;
    n_hit_c      = count3(note_c & eff_c);
    n_miss_c     = count3(note_c & ~eff_c);
    n_note_c     = count3(note_c);
    hits_sum_c   = {1'b0, hits} + 9'(n_hit_c);
    misses_sum_c = {1'b0, misses} + 9'(n_miss_c);
    hits_upd_c   = hits_sum_c[8] ? 8'hFF : hits_sum_c[7:0];
    misses_upd_c = misses_sum_c[8] ? 8'hFF : misses_sum_c[7:0];
    left_upd_c   = (notes_left < 8'(n_note_c)) ? 8'd0 : notes_left - 8'(n_note_c);
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: if (start) state_nxt = PLAY;
      PLAY:       if (judge_c && (slot_idx == SLOT_LAST)) state_nxt = DONE;
      default:    state_nxt = IDLE;
    endcase
  end

  // Flag values for the coming cycle
  always_comb begin
    playing_nxt = (state_nxt == PLAY);
    done_nxt    = (state_nxt == DONE);
  end

  // Chart registers, beat timing, hit flags and counters
  always_ff @(posedge clk) begin
    if (reset) begin
      red_sr     <= '0;
      blue_sr    <= '0;
      yellow_sr  <= '0;
      beat_cnt   <= '0;
      slot_idx   <= '0;
      hit_flag   <= '0;
      hits       <= '0;
      misses     <= '0;
      notes_left <= '0;
      beat       <= 1'b0;
      playing    <= 1'b0;
      done       <= 1'b0;
    end else begin
      beat    <= judge_c;
      playing <= playing_nxt;
      done    <= done_nxt;
      if (load_c) begin
        red_sr     <= red_in;
        blue_sr    <= blue_in;
        yellow_sr  <= yellow_in;
        notes_left <= total_notes_in;
        hits       <= '0;
        misses     <= '0;
        slot_idx   <= '0;
        beat_cnt   <= '0;
        hit_flag   <= '0;
      end else if (state == PLAY) begin
        if (judge_c) begin
          beat_cnt   <= '0;
          hit_flag   <= '0;
          hits       <= hits_upd_c;
          misses     <= misses_upd_c;
          notes_left <= left_upd_c;
          red_sr     <= {red_sr[SLOTS-2:0], 1'b0};
          blue_sr    <= {blue_sr[SLOTS-2:0], 1'b0};
          yellow_sr  <= {yellow_sr[SLOTS-2:0], 1'b0};
          slot_idx   <= slot_idx + IDX_W'(1);
        end else begin
          beat_cnt <= beat_cnt + CNT_W'(1);
          hit_flag <= hit_flag | pulse_c;
        end
      end
    end
  end

  assign lane_red    = red_sr[SLOTS-1 -: WINDOW];
  assign lane_blue   = blue_sr[SLOTS-1 -: WINDOW];
  assign lane_yellow = yellow_sr[SLOTS-1 -: WINDOW];

endmodule
